// File: rtl/uart_line_buffer.sv
// rtl/uart_line_buffer.sv - UART byte line buffer that releases whole lines (newline, full, flush or idle timeout) to a host printer
module uart_line_buffer #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_ch,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [7:0]              out_ch,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [15:0]             drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef logic [PW-1:0] ptr_t;

    ptr_t           wr_ptr_q, wr_ptr_d;
    ptr_t           rd_ptr_q, rd_ptr_d;
    ptr_t           cm_ptr_q, cm_ptr_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           armed_q, armed_d;

    logic [7:0]     mem_q [DEPTH];

    ptr_t           occupancy;
    ptr_t           committed;
    ptr_t           occ_next;
    logic           pop;
    logic           push;
    logic           drop;
    logic           full;
    logic           byte_valid;
    logic           pending;
    logic           timeout_hit;
    logic           commit;

    always_comb begin
        occupancy   = wr_ptr_q - rd_ptr_q;
        committed   = cm_ptr_q - rd_ptr_q;
        out_valid   = (committed != '0);
        out_last    = out_valid && (ptr_t'(rd_ptr_q + ptr_t'(1)) == cm_ptr_q);
        out_ch      = mem_q[rd_ptr_q[AW-1:0]];
        level       = occupancy;
        drop_cnt    = drop_cnt_q;

        pop         = out_valid && out_ready;
        // Bytes arriving in the first cycle after reset release are ignored.
        byte_valid  = in_valid && armed_q;
        full        = (occupancy == ptr_t'(DEPTH));
        push        = byte_valid && (!full || pop);
        drop        = byte_valid && full && !pop;

        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        occ_next    = wr_ptr_d - rd_ptr_d;

        pending     = (wr_ptr_q != cm_ptr_q);
        timeout_hit = pending && !push && (timer_q == TW'(TIMEOUT - 1));

        // All commit causes land on the newest write pointer, so they merge
        // naturally and cm_ptr can never move backward.
        commit      = (push && (in_ch == 8'h0A))
                   || (push && (occ_next == ptr_t'(DEPTH)))
                   || flush
                   || timeout_hit;
        cm_ptr_d    = commit ? wr_ptr_d : cm_ptr_q;

        timer_d     = timer_q;
        if (push || commit || !pending) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        armed_d     = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            timer_q    <= '0;
            drop_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            timer_q    <= timer_d;
            drop_cnt_q <= drop_cnt_d;
            armed_q    <= armed_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_ch;
        end
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// tb/tb_uart_line_buffer.sv - directed self-checking bench for uart_line_buffer (DEPTH=4, TIMEOUT=8)
module tb_uart_line_buffer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic        flush;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        out_last;
    logic        out_ready;
    logic [15:0] drop_cnt;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    uart_line_buffer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] ch);
        in_valid = 1'b1;
        in_ch    = ch;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_ch     = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_level", 32'(level),     32'd0);
        check("rst_drop",  32'(drop_cnt),  32'd0);
        tick();
        tick();
        reset = 1'b1;

        // A byte offered in the first cycle after release must be ignored.
        push(8'h55);
        check("post_rst_ignore_level", 32'(level), 32'd0);
        tick();

        // "hi\n" with the host always ready.
        out_ready = 1'b1;
        push(8'h68);
        check("hi_v0", 32'(out_valid), 32'd0);
        check("hi_l0", 32'(level), 32'd1);
        push(8'h69);
        check("hi_v1", 32'(out_valid), 32'd0);
        push(8'h0A);
        check("hi_v2",    32'(out_valid), 32'd1);
        check("hi_ch0",   32'(out_ch),    32'h68);
        check("hi_last0", 32'(out_last),  32'd0);
        tick();
        check("hi_ch1",   32'(out_ch),    32'h69);
        check("hi_last1", 32'(out_last),  32'd0);
        tick();
        check("hi_ch2",   32'(out_ch),    32'h0A);
        check("hi_last2", 32'(out_last),  32'd1);
        tick();
        check("hi_empty", 32'(out_valid), 32'd0);
        check("hi_level", 32'(level),     32'd0);

        // "ab" released only by the idle timeout, 8 cycles after 'b'.
        out_ready = 1'b0;
        push(8'h61);
        push(8'h62);
        for (int i = 0; i < 7; i++) tick();
        check("to_early", 32'(out_valid), 32'd0);
        tick();
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_ch_a",  32'(out_ch),    32'h61);
        check("to_last_a", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        tick();
        check("to_ch_b",   32'(out_ch),   32'h62);
        check("to_last_b", 32'(out_last), 32'd1);
        tick();
        check("to_empty", 32'(out_valid), 32'd0);

        // Overflow: six bytes into a four-entry buffer with the host stalled.
        out_ready = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("ov_v3", 32'(out_valid), 32'd0);
        push(8'h34);
        check("ov_v4",     32'(out_valid), 32'd1);
        check("ov_level4", 32'(level),     32'd4);
        push(8'h35);
        push(8'h36);
        check("ov_drop", 32'(drop_cnt), 32'd2);
        check("ov_level", 32'(level),   32'd4);
        check("ov_head", 32'(out_ch),   32'h31);

        // Full buffer, pop and push in the same cycle.
        out_ready = 1'b1;
        push(8'h37);
        check("fp_level", 32'(level),    32'd4);
        check("fp_drop",  32'(drop_cnt), 32'd2);
        check("fp_ch0",   32'(out_ch),   32'h32);
        tick();
        check("fp_ch1", 32'(out_ch), 32'h33);
        tick();
        check("fp_ch2", 32'(out_ch), 32'h34);
        tick();
        check("fp_ch3",   32'(out_ch),   32'h37);
        check("fp_last3", 32'(out_last), 32'd1);
        tick();
        check("fp_empty", 32'(level), 32'd0);

        // Push and flush in the same cycle on an empty buffer.
        out_ready = 1'b0;
        flush     = 1'b1;
        push(8'h41);
        flush     = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd1);
        check("fl_ch",    32'(out_ch),    32'h41);
        check("fl_last",  32'(out_last),  32'd1);
        out_ready = 1'b1;
        tick();
        check("fl_empty", 32'(level), 32'd0);

        // Asynchronous reset with three committed bytes pending.
        out_ready = 1'b0;
        push(8'h70);
        push(8'h71);
        push(8'h0A);
        check("ar_level_pre", 32'(level),     32'd3);
        check("ar_valid_pre", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_level", 32'(level),     32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        push(8'h78);
        push(8'h0A);
        check("ar_x_valid", 32'(out_valid), 32'd1);
        check("ar_x_ch",    32'(out_ch),    32'h78);
        check("ar_x_drop",  32'(drop_cnt),  32'd0);
        out_ready = 1'b1;
        tick();
        check("ar_nl_ch",   32'(out_ch),   32'h0A);
        check("ar_nl_last", 32'(out_last), 32'd1);
        tick();
        check("ar_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer entries; power of two, at least 4.
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles before a forced flush of a partial line; at least 1.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  UART byte strobe from SimTop io_uart_out_valid; no backpressure.
REQ-007 in_ch  input  8  UART byte from SimTop io_uart_out_ch.
REQ-008 flush  input  1  host request to commit all buffered bytes (end of simulation).
REQ-009 out_valid  output  1  committed byte available to the host printer.
REQ-010 out_ch  output  8  byte at the read pointer.
REQ-011 out_last  output  1  out_ch is the final byte of the current committed region.
REQ-012 out_ready  input  1  host accepts the byte; transfer occurs when out_valid && out_ready.
REQ-013 drop_cnt  output  16  saturating count of bytes lost to overflow.
REQ-014 level  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL hold three pointers wr_ptr, rd_ptr, cm_ptr, each log2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH; occupancy = wr_ptr-rd_ptr; committed = cm_ptr-rd_ptr.
REQ-016 Push: in_valid and (occupancy<DEPTH or a pop occurs in the same cycle) -> write in_ch at wr_ptr and increment wr_ptr.
REQ-017 Drop: in_valid, occupancy==DEPTH and no pop in the same cycle -> byte discarded and drop_cnt+1, saturating at 0xFFFF.
REQ-018 Pop: out_valid && out_ready -> increment rd_ptr.
REQ-019 out_valid SHALL equal (committed != 0), combinationally from registered pointers; out_ch SHALL be the entry at rd_ptr.
REQ-020 out_last SHALL equal out_valid && (rd_ptr+1 == cm_ptr).
REQ-021 Commit on newline: a pushed byte equal to 0x0A -> cm_ptr <= wr_ptr+1 in the same cycle.
REQ-022 Commit on full: a push that makes occupancy DEPTH -> cm_ptr <= wr_ptr+1.
REQ-023 Commit on flush: flush high -> cm_ptr <= wr_ptr (+1 if a push occurs in the same cycle).
REQ-024 Idle timer: counts while uncommitted bytes (wr_ptr != cm_ptr) exist and no push occurs; clears on push or commit; reaching TIMEOUT-1 -> cm_ptr <= wr_ptr and timer clears.
REQ-025 Causes in the same cycle SHALL merge into one commit to the newest wr_ptr; commit never moves cm_ptr backward.
REQ-026 Data SHALL leave in arrival order; no byte is duplicated; bytes are lost only per REQ-017.
REQ-027 Buffer storage needs no reset; a pop after wrap-around SHALL read correct data.

Reset
REQ-028 While reset is low: pointers=0, timer=0, drop_cnt=0, out_valid=0, out_last=0, level=0; out_ch don't-care.
REQ-029 Reset asserted mid-line or mid-drain SHALL discard all buffered bytes immediately, without waiting for a clock edge.
REQ-030 in_valid SHALL be ignored while reset is low and in the first cycle after release.

Verification
REQ-031 Push "hi\n" (0x68,0x69,0x0A) with out_ready=1 -> out_valid stays low until the 0x0A cycle; then three bytes in order, with out_last only on 0x0A.
REQ-032 Push "ab" with no newline, TIMEOUT=8, then idle -> out_valid rises 8 cycles after the last push; out_last set on 'b'.
REQ-033 DEPTH=4, out_ready=0, push 6 non-newline bytes -> first 4 committed on the 4th push; drop_cnt=2; level=4.
REQ-034 Full buffer with out_ready=1 and in_valid in the same cycle -> push accepted, drop_cnt unchanged, level stays 4.
REQ-035 Push 0x41 and assert flush in the same cycle on an empty buffer -> next cycle out_valid=1, out_ch=0x41, out_last=1.
REQ-036 Reset pulsed low while 3 committed bytes are pending -> out_valid=0 and level=0 asynchronously; a later "x\n" drains correctly.
